spi_slave_regif: RTL and testbench

- Register-access protocol layer that sits directly downstream of the byte-level SPI slave (`spi_slave`, `BIT_WIDTH`=8).
- Consumes its received bytes (`rx_data`/`rx_valid`, i.e. slave `rdata`/`done`) and returns the next transmit byte (`tx_data`, i.e. slave `wdata`).
- Translates each nss-framed byte stream into accesses on a simple single-cycle register bus.
- Frame format: byte0 is the command; following bytes are write data or read dummies, with auto-incrementing address.

---
 rtl/spi_slave_regif_pkg.sv | 9 +
 rtl/spi_slave_regif_if.sv | 14 +
 rtl/spi_slave_regif_sync2.sv | 21 ++
 rtl/spi_slave_regif.sv | 96 +++++++++
 tb/tb_spi_slave_regif.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_regif_pkg.sv
// Shared types and defaults for the SPI register-access layer.
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_ADDR_W = 7;
  localparam int CMD_RW_BIT = SPI_DATA_W - 1;
  localparam logic [SPI_DATA_W-1:0] SPI_STATUS_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} regif_state_e;
endpackage

// File: rtl/spi_slave_regif_if.sv
// Single-cycle register bus driven by the SPI register-access layer.
interface spi_slave_regif_if import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W,
  parameter int ADDR_W = SPI_ADDR_W
);
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_rd;
  logic [DATA_W-1:0] reg_rdata;

  modport master (output reg_addr, reg_wr, reg_wdata, reg_rd, input reg_rdata);
  modport slave  (input reg_addr, reg_wr, reg_wdata, reg_rd, output reg_rdata);
endinterface

// File: rtl/spi_slave_regif_sync2.sv
// Two-flop synchroniser with configurable reset value, shared by SPI blocks.
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_slave_regif.sv
// Turns nss-framed SPI byte streams (cmd byte + data/dummy bytes) into
// auto-incrementing accesses on a single-cycle register bus.
module spi_slave_regif import spi_pkg::*; #(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                ADDR_W      = SPI_ADDR_W,
  parameter logic [DATA_W-1:0] STATUS_BYTE = SPI_STATUS_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nss,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  spi_slave_regif_if.master bus,
  output logic              frame_active
);
  if (DATA_W != ADDR_W + 1) begin : g_bad_width
    $error("spi_slave_regif: DATA_W must equal ADDR_W+1");
  end

  logic              nss_s;
  regif_state_e      state;
  logic [ADDR_W-1:0] addr_q;
  logic              cmd_is_rd;
  logic [ADDR_W-1:0] cmd_addr;

  spi_sync2 #(.RST_VAL(1'b1)) u_nss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (nss),
    .q     (nss_s)
  );

  // The R/W flag sits directly above the address field in the command byte.
  assign cmd_is_rd = rx_data[ADDR_W];
  assign cmd_addr  = rx_data[ADDR_W-1:0];

  always_comb begin
    bus.reg_wr    = 1'b0;
    bus.reg_rd    = 1'b0;
    bus.reg_addr  = addr_q;
    bus.reg_wdata = '0;
    if (rx_valid) begin
      case (state)
        CMD: if (cmd_is_rd) begin
          bus.reg_rd   = 1'b1;
          bus.reg_addr = cmd_addr;
        end
        WRITE: begin
          bus.reg_wr    = 1'b1;
          bus.reg_wdata = rx_data;
        end
        READ:    bus.reg_rd = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      tx_data      <= STATUS_BYTE;
      frame_active <= 1'b0;
    end else begin
      frame_active <= !nss_s;
      if (rx_valid) begin
        case (state)
          CMD: begin
            if (cmd_is_rd) begin
              state   <= READ;
              addr_q  <= cmd_addr + 1'b1;
              tx_data <= bus.reg_rdata;
            end else begin
              state  <= WRITE;
              addr_q <= cmd_addr;
            end
          end
          WRITE: addr_q <= addr_q + 1'b1;
          READ: begin
            addr_q  <= addr_q + 1'b1;
            tx_data <= bus.reg_rdata;
          end
          default: ;
        endcase
      end
      if (state == IDLE && !nss_s) state <= CMD;
      // A byte finishing as nss rises still gets its strobe above; only the
      // state and the idle status byte are overridden here.
      if (nss_s) begin
        state   <= IDLE;
        tx_data <= STATUS_BYTE;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed + randomized frames against a frame-level reference model.
module tb_spi_slave_regif;
  localparam logic [7:0] STATUS = 8'hA5;

  logic       clk, rst_n, nss, rx_valid, frame_active;
  logic [7:0] rx_data, tx_data;

  int vectors = 0;
  int miscompares = 0;

  spi_slave_regif_if #(.DATA_W(8), .ADDR_W(7)) bus ();

  spi_slave_regif #(.DATA_W(8), .ADDR_W(7), .STATUS_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nss          (nss),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .bus          (bus.master),
    .frame_active (frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file on the bus; a preload port fills it at start-up.
  logic [7:0] bus_mem [128];
  logic       ld_en;
  logic [6:0] ld_addr;
  logic [7:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) bus_mem[ld_addr] <= ld_data;
    else if (bus.reg_wr) bus_mem[bus.reg_addr] <= bus.reg_wdata;
  end
  assign bus.reg_rdata = bus_mem[bus.reg_addr];

  // Reference model: expected memory and frame-level protocol state.
  logic [7:0] ref_mem [128];
  logic [6:0] m_addr;
  logic [7:0] m_tx;
  bit         m_active, m_first, m_read;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    logic       exp_wr, exp_rd;
    logic [6:0] exp_a;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    exp_a  = m_addr;
    if (m_active) begin
      if (m_first) begin
        m_first = 0;
        m_read  = b[7];
        if (m_read) begin
          exp_rd = 1'b1;
          exp_a  = b[6:0];
          m_tx   = ref_mem[b[6:0]];
          m_addr = b[6:0] + 7'd1;
        end else begin
          m_addr = b[6:0];
        end
      end else if (m_read) begin
        exp_rd = 1'b1;
        exp_a  = m_addr;
        m_tx   = ref_mem[m_addr];
        m_addr = m_addr + 7'd1;
      end else begin
        exp_wr = 1'b1;
        exp_a  = m_addr;
        ref_mem[m_addr] = b;
        m_addr = m_addr + 7'd1;
      end
      if (last) begin
        m_active = 0;
        m_tx     = STATUS;
      end
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    #2;
    chk("reg_wr", bus.reg_wr, exp_wr);
    chk("reg_rd", bus.reg_rd, exp_rd);
    chk("reg_addr", bus.reg_addr, exp_a);
    if (exp_wr) chk("reg_wdata", bus.reg_wdata, b);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("tx_data", tx_data, m_tx);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic frame_begin();
    chk("tx_idle", tx_data, STATUS);
    nss = 1'b0;
    repeat (4) @(negedge clk);
    m_active = 1;
    m_first  = 1;
    chk("frame_active_hi", frame_active, 1'b1);
  endtask

  task automatic frame_end();
    nss = 1'b1;
    repeat (4) @(negedge clk);
    m_active = 0;
    m_tx     = STATUS;
    chk("tx_after_frame", tx_data, STATUS);
    chk("frame_active_lo", frame_active, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; nss = 1'b1; rx_valid = 1'b0; rx_data = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    m_addr = '0; m_tx = STATUS; m_active = 0; m_first = 0; m_read = 0;

    @(negedge clk);
    chk("rst_tx", tx_data, STATUS);
    chk("rst_wr", bus.reg_wr, 1'b0);
    chk("rst_rd", bus.reg_rd, 1'b0);
    chk("rst_wdata", bus.reg_wdata, 8'h00);
    chk("rst_addr", bus.reg_addr, 7'h00);
    chk("rst_frame", frame_active, 1'b0);

    ld_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      ld_addr = 7'(i);
      case (i)
        1:       ld_data = 8'hC3;
        'h20:    ld_data = 8'h5A;
        'h21:    ld_data = 8'h3C;
        default: ld_data = 8'($urandom);
      endcase
      ref_mem[i] = ld_data;
      @(negedge clk);
    end
    ld_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write burst
    frame_begin();
    send_byte(8'h10, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    frame_end();
    chk("wr_mem10", bus_mem[7'h10], 8'hAB);
    chk("wr_mem11", bus_mem[7'h11], 8'hCD);

    // read burst
    frame_begin();
    send_byte(8'hA0, 0);
    chk("rd_tx0", tx_data, 8'h5A);
    send_byte(8'h00, 0);
    chk("rd_tx1", tx_data, 8'h3C);
    send_byte(8'h00, 0);
    frame_end();

    // address wrap
    frame_begin();
    send_byte(8'h7F, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    frame_end();
    chk("wrap_mem7f", bus_mem[7'h7F], 8'h11);
    chk("wrap_mem00", bus_mem[7'h00], 8'h22);

    // nss rises in the same cycle as the second data byte
    frame_begin();
    send_byte(8'h40, 0); send_byte(8'h5E, 0);
    nss = 1'b1;
    @(negedge clk);
    send_byte(8'h6F, 1);
    chk("edge_mem41", bus_mem[7'h41], 8'h6F);
    send_byte(8'h99, 0);
    chk("edge_frame", frame_active, 1'b0);

    // reset mid-frame
    frame_begin();
    send_byte(8'h30, 0); send_byte(8'($urandom), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_tx", tx_data, STATUS);
    chk("mrst_wr", bus.reg_wr, 1'b0);
    chk("mrst_rd", bus.reg_rd, 1'b0);
    chk("mrst_wdata", bus.reg_wdata, 8'h00);
    chk("mrst_addr", bus.reg_addr, 7'h00);
    chk("mrst_frame", frame_active, 1'b0);
    nss = 1'b1;
    m_addr = '0; m_tx = STATUS; m_active = 0; m_first = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame_begin();
    send_byte(8'h05, 0); send_byte(8'h77, 0);
    frame_end();
    chk("post_rst_mem05", bus_mem[7'h05], 8'h77);

    // read of address 1: status goes out during cmd, register afterwards
    frame_begin();
    send_byte(8'h81, 0);
    chk("e2e_tx", tx_data, 8'hC3);
    send_byte(8'hFF, 0);
    frame_end();

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      frame_begin();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++)
        send_byte(8'($urandom), 0);
      frame_end();
    end
    for (int i = 0; i < 128; i++)
      chk("mem_final", bus_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
